// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receiver slice.
//   rx_state_t       : receiver FSM state encoding
//   DEFAULT_BAUD_DIV : clocks per bit at 100 MHz / 115200 baud
//   UART_DATA_BITS   : default payload width
//   even_parity()    : even-parity bit of a payload
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 868;
    localparam int UART_DATA_BITS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Parity bit that makes the total number of ones even. Callers
    // zero-extend narrower payloads, which does not change the result.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Byte-side handshake bundle between the UART receiver and its consumer.
//   data_out       : received byte, valid while valid_out is high
//   valid_out      : byte available, held until accepted
//   ready_in       : consumer accepts data_out
//   frame_err_out  : one-cycle pulse, stop bit sampled low
//   overrun_out    : one-cycle pulse, completed byte dropped
//   busy_out       : receiver FSM not idle
//   parity_err_out : one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 frame_err_out;
    logic                 overrun_out;
    logic                 busy_out;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_out;
`endif

    modport master (
        input  ready_in,
`ifdef UART_RX_PARITY_EN
        output parity_err_out,
`endif
        output data_out, valid_out, frame_err_out, overrun_out, busy_out
    );

    modport slave (
        output ready_in,
`ifdef UART_RX_PARITY_EN
        input  parity_err_out,
`endif
        input  data_out, valid_out, frame_err_out, overrun_out, busy_out
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
//   clk_in   : destination clock
//   rst_n_in : asynchronous active-low reset
//   d_in     : asynchronous input
//   q_out    : synchronized output, two cycles of latency
// RESET_VAL sets the value both flops take in reset.
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Byte-oriented UART receiver with mid-bit sampling and valid/ready output.
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   rx_in    : raw serial line, idle high, asynchronous to clk_in
//   bus      : uart_rx_if.master (data/valid/ready, error pulses, busy)
// Parameters: BAUD_DIV clocks per bit (4..65535), DATA_BITS payload width.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit + parity_err_out).
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rx_in,
    uart_rx_if.master  bus
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 half_hit_s;
    logic                 bit_hit_s;
    logic [CNT_W-1:0]     cnt_d;

    rx_state_t            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad_q;
    logic                 parity_err_q;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (rx_in),
        .q_out    (rx_s)
    );

    // Sample-point strobes and bit-period counter next value. The counter
    // restarts at every sample point and is parked at zero while idle or in
    // BREAK, so each START begins a fresh half-bit count.
    always_comb begin
        half_hit_s = (cnt_q == HALF_LAST);
        bit_hit_s  = (cnt_q == BIT_LAST);
        cnt_d      = cnt_q + CNT_W'(1);
        case (state_q)
            ST_IDLE, ST_BREAK: cnt_d = '0;
            ST_START: begin
                if (half_hit_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (bit_hit_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Receiver FSM with registered byte output, handshake and error pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // A handshake drops valid; a byte loading below in the same
            // cycle overrides this.
            if (valid_q && bus.ready_in) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (half_hit_s) begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_hit_s) begin
                        // LSB arrives first, so shifting in at the MSB
                        // leaves the byte in natural order.
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_hit_s) begin
                        parity_bad_q <= rx_s ^ even_parity(32'(shift_q));
                        state_q      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_hit_s) begin
                        if (!rx_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end else begin
                            // Returning to IDLE mid-stop-bit lets the next
                            // start edge be caught with no idle gap.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else
`endif
                            if (!valid_q || bus.ready_in) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    // Wait for the line to recover before re-arming.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out      = data_q;
    assign bus.valid_out     = valid_q;
    assign bus.frame_err_out = frame_err_q;
    assign bus.overrun_out   = overrun_q;
    assign bus.busy_out      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err_out = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with BAUD_DIV = 16. Serial frames are
// driven bit by bit; expected bytes are queued when a frame is sent and
// compared when the DUT hands them over. Frame cases come from a table;
// latency, glitch, break, overrun, reset and parity are hand sequences.
// Optional feature macro: UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BAUD = 16;
    localparam int DB   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rx    = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.BAUD_DIV(BAUD), .DATA_BITS(DB)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rx_in    (rx),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int vcnt     = 0;
    int fcnt     = 0;
    int ocnt     = 0;
    int pcnt     = 0;
    int vrise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and scoreboard
    always @(negedge clk) begin
        prev_valid <= bus.valid_out;
        if (bus.valid_out) vcnt <= vcnt + 1;
        if (bus.valid_out && !prev_valid) vrise_cyc <= cyc;
        if (bus.frame_err_out) fcnt <= fcnt + 1;
        if (bus.overrun_out) ocnt <= ocnt + 1;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_err_out) pcnt <= pcnt + 1;
`endif
        if (bus.valid_out && bus.ready_in) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                logic [7:0] e;
                e = sb_q.pop_front();
                chk("sb_data", 32'(bus.data_out), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(BAUD);
    endtask

    // Start bit plus data bits (plus correct parity when enabled).
    task automatic send_payload(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_payload(d);
        drive_bit(stop);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(par_bit);
        drive_bit(1'b1);
    endtask
`endif

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, f0, o0, c0, b;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h55, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h81, 1'b1, 1'b1, 1'b0};

        bus.ready_in = 1'b0;
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_data",  32'(bus.data_out), 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_ferr",  32'(bus.frame_err_out), 32'd0);
        chk("rst_ovr",   32'(bus.overrun_out), 32'd0);
        chk("rst_busy",  32'(bus.busy_out), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Latency of a clean 0xA5 frame
        bus.ready_in = 1'b1;
        v0 = vcnt; f0 = fcnt; o0 = ocnt;
        c0 = cyc;
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(BAUD);
        chk("lat_cycles", 32'(vrise_cyc - c0), 32'(2 + 1 + BAUD / 2 + 9 * BAUD));
        chk("lat_valid_cycles", 32'(vcnt - v0), 32'd1);
        chk("lat_no_ferr", 32'(fcnt - f0), 32'd0);
        chk("lat_no_ovr", 32'(ocnt - o0), 32'd0);

        // Short low glitch: false start
        v0 = vcnt; f0 = fcnt; b = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i == 4) rx = 1'b1;
            if (bus.busy_out) b++;
        end
        chk("glitch_busy_cycles", 32'(b), 32'd8);
        chk("glitch_no_valid", 32'(vcnt - v0), 32'd0);
        chk("glitch_no_ferr", 32'(fcnt - f0), 32'd0);

        // Framing error with line held low: stays in BREAK
        v0 = vcnt; f0 = fcnt;
        send_payload(8'h3C);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        chk("brk_busy_held", 32'(bus.busy_out), 32'd1);
        chk("brk_ferr_once", 32'(fcnt - f0), 32'd1);
        chk("brk_no_valid", 32'(vcnt - v0), 32'd0);
        rx = 1'b1;
        tick(4);
        chk("brk_released", 32'(bus.busy_out), 32'd0);
        sb_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        tick(BAUD);
        chk("brk_then_55", 32'(sb_q.size()), 32'd0);

        // Table of frames with ready held high
        for (int i = 0; i < 6; i++) begin
            v0 = vcnt; f0 = fcnt;
            if (tbl[i].exp_valid) sb_q.push_back(tbl[i].data);
            send_frame(tbl[i].data, tbl[i].stop);
            tick(2 * BAUD);
            chk($sformatf("tbl%0d_valid", i), 32'(vcnt - v0), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_ferr", i), 32'(fcnt - f0), 32'(tbl[i].exp_ferr));
            chk($sformatf("tbl%0d_idle", i), 32'(bus.busy_out), 32'd0);
            chk($sformatf("tbl%0d_sb", i), 32'(sb_q.size()), 32'd0);
        end

        // Back-to-back frames with ready low: overrun
        bus.ready_in = 1'b0;
        o0 = ocnt;
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(BAUD);
        chk("ovr_pulse", 32'(ocnt - o0), 32'd1);
        chk("ovr_valid_held", 32'(bus.valid_out), 32'd1);
        chk("ovr_data_held", 32'(bus.data_out), 32'h11);
        bus.ready_in = 1'b1;
        tick(2);
        chk("ovr_valid_clr", 32'(bus.valid_out), 32'd0);
        chk("ovr_sb", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of DATA bit 3 with a byte pending
        bus.ready_in = 1'b0;
        f0 = fcnt; o0 = ocnt;
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(BAUD);
        chk("mid_pending_valid", 32'(bus.valid_out), 32'd1);
        chk("mid_pending_data", 32'(bus.data_out), 32'h5A);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        tick(BAUD / 2);
        chk("mid_busy_before", 32'(bus.busy_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(bus.data_out), 32'd0);
        chk("mid_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy_out), 32'd0);
        chk("mid_rst_ferr", 32'(bus.frame_err_out), 32'd0);
        chk("mid_rst_ovr", 32'(bus.overrun_out), 32'd0);
        sb_q.delete();
        rx = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2 * BAUD);
        bus.ready_in = 1'b1;
        v0 = vcnt;
        sb_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1);
        tick(BAUD);
        chk("post_rst_F0", 32'(sb_q.size()), 32'd0);
        chk("post_rst_valid", 32'(vcnt - v0), 32'd1);
        chk("post_rst_no_ferr", 32'(fcnt - f0), 32'd0);
        chk("post_rst_no_ovr", 32'(ocnt - o0), 32'd0);

`ifdef UART_RX_PARITY_EN
        begin
            int p0;
            p0 = pcnt; v0 = vcnt;
            send_frame_par(8'h07, 1'b0);
            tick(BAUD);
            chk("par_bad_pulse", 32'(pcnt - p0), 32'd1);
            chk("par_bad_no_valid", 32'(vcnt - v0), 32'd0);
            sb_q.push_back(8'h07);
            send_frame_par(8'h07, 1'b1);
            tick(BAUD);
            chk("par_good_no_pulse", 32'(pcnt - p0), 32'd1);
            chk("par_good_sb", 32'(sb_q.size()), 32'd0);
        end
`endif

        tick(4);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
